// File: rtl/l2_arbiter.sv
// Purpose : two-requester (instruction / data) arbiter onto one shared L2 bus.
//           Fair round-robin on ties; request/ack routing is combinational.
// Latency : grant 1 cycle after request when uncontested; 2 idle cycles between
//           L2 transactions (RECOVER + IDLE).
// Backpressure: a requester holds cyc/stb until its ack. The loser of a tie waits
//           for the winner's full transaction plus 2 cycles.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_* / d_*                  instruction / data requester buses (cyc, stb, we, adr, sel, dat_m -> ack, dat_s)
//   l2_*                       shared L2 bus (cyc, stb, we, adr, sel, dat_m -> ack, dat_s)
//   contention_cnt             saturating count of cycles where both requesters contended
module l2_arbiter #(
    parameter int ADR_W = 12,
    parameter int DAT_W = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 i_cyc,
    input  logic                 i_stb,
    input  logic                 i_we,
    input  logic [ADR_W-1:0]     i_adr,
    input  logic [DAT_W/8-1:0]   i_sel,
    input  logic [DAT_W-1:0]     i_dat_m,
    output logic                 i_ack,
    output logic [DAT_W-1:0]     i_dat_s,

    input  logic                 d_cyc,
    input  logic                 d_stb,
    input  logic                 d_we,
    input  logic [ADR_W-1:0]     d_adr,
    input  logic [DAT_W/8-1:0]   d_sel,
    input  logic [DAT_W-1:0]     d_dat_m,
    output logic                 d_ack,
    output logic [DAT_W-1:0]     d_dat_s,

    output logic                 l2_cyc,
    output logic                 l2_stb,
    output logic                 l2_we,
    output logic [ADR_W-1:0]     l2_adr,
    output logic [DAT_W/8-1:0]   l2_sel,
    output logic [DAT_W-1:0]     l2_dat_m,
    input  logic                 l2_ack,
    input  logic [DAT_W-1:0]     l2_dat_s,

    output logic [15:0]          contention_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;     // 1: data port was granted most recently
    logic [15:0] cnt_q, cnt_d;

    logic        i_req, d_req;

    assign i_req = i_cyc & i_stb;
    assign d_req = d_cyc & d_stb;

    // Next-state, last-grant and contention counter.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    // Tie: favour whoever was not granted last.
                    if (last_d_q) begin
                        state_d  = GRANT_I;
                        last_d_d = 1'b0;
                    end else begin
                        state_d  = GRANT_D;
                        last_d_d = 1'b1;
                    end
                end else if (i_req) begin
                    state_d  = GRANT_I;
                    last_d_d = 1'b0;
                end else if (d_req) begin
                    state_d  = GRANT_D;
                    last_d_d = 1'b1;
                end
            end
            // Completion or abort both end the grant; the other port cannot steal it.
            GRANT_I: if (!i_req || l2_ack) state_d = RECOVER;
            GRANT_D: if (!d_req || l2_ack) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (i_req && d_req && (state_q != RECOVER) && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

    // Combinational bus routing: the granted requester drives L2 directly,
    // so an abort drops l2_cyc/l2_stb in the same cycle.
    always_comb begin
        l2_cyc   = 1'b0;
        l2_stb   = 1'b0;
        l2_we    = 1'b0;
        l2_adr   = '0;
        l2_sel   = '0;
        l2_dat_m = '0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;

        case (state_q)
            GRANT_I: begin
                l2_cyc   = i_cyc;
                l2_stb   = i_stb;
                l2_we    = i_we;
                l2_adr   = i_adr;
                l2_sel   = i_sel;
                l2_dat_m = i_dat_m;
                i_ack    = l2_ack;
            end
            GRANT_D: begin
                l2_cyc   = d_cyc;
                l2_stb   = d_stb;
                l2_we    = d_we;
                l2_adr   = d_adr;
                l2_sel   = d_sel;
                l2_dat_m = d_dat_m;
                d_ack    = l2_ack;
            end
            default: ; // IDLE / RECOVER: bus parked, stray l2_ack ignored
        endcase
    end

    // Read data is broadcast; only the ack qualifies it.
    assign i_dat_s        = l2_dat_s;
    assign d_dat_s        = l2_dat_s;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: single request, contention/alternation, abort,
// reset mid-transaction, counter saturation.
module tb_l2_arbiter;

    localparam int ADR_W = 12;
    localparam int DAT_W = 128;
    localparam int SEL_W = DAT_W / 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_cyc, i_stb, i_we;
    logic [ADR_W-1:0]   i_adr;
    logic [SEL_W-1:0]   i_sel;
    logic [DAT_W-1:0]   i_dat_m;
    logic               i_ack;
    logic [DAT_W-1:0]   i_dat_s;
    logic               d_cyc, d_stb, d_we;
    logic [ADR_W-1:0]   d_adr;
    logic [SEL_W-1:0]   d_sel;
    logic [DAT_W-1:0]   d_dat_m;
    logic               d_ack;
    logic [DAT_W-1:0]   d_dat_s;
    logic               l2_cyc, l2_stb, l2_we;
    logic [ADR_W-1:0]   l2_adr;
    logic [SEL_W-1:0]   l2_sel;
    logic [DAT_W-1:0]   l2_dat_m;
    logic               l2_ack;
    logic [DAT_W-1:0]   l2_dat_s;
    logic [15:0]        contention_cnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [DAT_W-1:0] RD_PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [DAT_W-1:0] WR_PAT = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_5A5A;

    l2_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
        .i_dat_m(i_dat_m), .i_ack(i_ack), .i_dat_s(i_dat_s),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
        .d_dat_m(d_dat_m), .d_ack(d_ack), .d_dat_s(d_dat_s),
        .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr), .l2_sel(l2_sel),
        .l2_dat_m(l2_dat_m), .l2_ack(l2_ack), .l2_dat_s(l2_dat_s),
        .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs are driven here, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_sel = '0; i_dat_m = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_sel = '0; d_dat_m = '0;
        l2_ack = 0; l2_dat_s = RD_PAT;

        // ---- reset state ----
        tick(); tick();
        #1;
        chk("rst_l2_cyc",   128'(l2_cyc), 128'd0);
        chk("rst_l2_stb",   128'(l2_stb), 128'd0);
        chk("rst_l2_adr",   128'(l2_adr), 128'd0);
        chk("rst_l2_dat_m", l2_dat_m,     128'd0);
        chk("rst_acks",     128'({i_ack, d_ack}), 128'd0);
        chk("rst_cnt",      128'(contention_cnt), 128'd0);
        chk("rst_i_dat_s",  i_dat_s, RD_PAT);
        chk("rst_d_dat_s",  d_dat_s, RD_PAT);

        // ---- single instruction read, ack on 3rd granted cycle ----
        tick();
        rst_n = 1; i_cyc = 1; i_stb = 1; i_adr = 12'h012; i_sel = '1;
        #1;
        chk("t1_idle_cyc", 128'(l2_cyc), 128'd0);
        tick();                                   // -> GRANT_I
        #1;
        chk("t1_gnt_cyc",  128'(l2_cyc), 128'd1);
        chk("t1_gnt_adr",  128'(l2_adr), 128'h012);
        chk("t1_gnt_sel",  128'(l2_sel), 128'hFFFF);
        chk("t1_noack",    128'(i_ack),  128'd0);
        tick(); tick();
        l2_ack = 1;
        #1;
        chk("t1_i_ack",    128'(i_ack), 128'd1);
        chk("t1_d_ack",    128'(d_ack), 128'd0);
        chk("t1_rdata",    i_dat_s,     RD_PAT);
        tick();                                   // -> RECOVER, stray ack stays high
        i_cyc = 0; i_stb = 0;
        #1;
        chk("t1_rec_cyc",  128'(l2_cyc), 128'd0);
        chk("t1_rec_ack",  128'(i_ack),  128'd0);
        tick();                                   // -> IDLE
        l2_ack = 0;
        #1;
        chk("t1_idle2_cyc", 128'(l2_cyc), 128'd0);
        chk("t1_cnt",       128'(contention_cnt), 128'd0);

        // ---- contention right after reset, then strict alternation ----
        rst_n = 0;
        tick();
        rst_n = 1;
        i_cyc = 1; i_stb = 1; i_adr = 12'h100; i_we = 0;
        d_cyc = 1; d_stb = 1; d_adr = 12'h200; d_we = 1; d_sel = 16'h00FF; d_dat_m = WR_PAT;
        tick();                                   // IDLE tie -> GRANT_D, cnt 1
        #1;
        chk("c_g1_adr",  128'(l2_adr), 128'h200);
        chk("c_g1_we",   128'(l2_we),  128'd1);
        chk("c_g1_dat",  l2_dat_m,     WR_PAT);
        chk("c_g1_sel",  128'(l2_sel), 128'h00FF);
        chk("c_g1_cnt",  128'(contention_cnt), 128'd1);
        tick();                                   // still GRANT_D, cnt 2
        l2_ack = 1;
        #1;
        chk("c_g1_dack", 128'(d_ack), 128'd1);
        chk("c_g1_iack", 128'(i_ack), 128'd0);
        chk("c_g1_cnt2", 128'(contention_cnt), 128'd2);
        tick();                                   // -> RECOVER, cnt 3
        l2_ack = 0;
        #1;
        chk("c_rec_cyc", 128'(l2_cyc), 128'd0);
        chk("c_rec_cnt", 128'(contention_cnt), 128'd3);
        tick();                                   // RECOVER not counted -> IDLE
        #1;
        chk("c_idle_cnt", 128'(contention_cnt), 128'd3);
        chk("c_idle_cyc", 128'(l2_cyc), 128'd0);
        tick();                                   // -> GRANT_I, cnt 4
        l2_ack = 1;
        #1;
        chk("c_g2_adr",  128'(l2_adr), 128'h100);
        chk("c_g2_we",   128'(l2_we),  128'd0);
        chk("c_g2_iack", 128'(i_ack),  128'd1);
        chk("c_g2_dack", 128'(d_ack),  128'd0);
        chk("c_g2_cnt",  128'(contention_cnt), 128'd4);
        tick();                                   // -> RECOVER, cnt 5
        l2_ack = 0;
        tick();                                   // -> IDLE
        tick();                                   // -> GRANT_D, cnt 6
        #1;
        chk("c_g3_adr",  128'(l2_adr), 128'h200);
        chk("c_g3_cnt",  128'(contention_cnt), 128'd6);
        l2_ack = 1;
        tick();                                   // -> RECOVER, cnt 7
        l2_ack = 0;
        tick();                                   // -> IDLE
        tick();                                   // -> GRANT_I, cnt 8
        #1;
        chk("c_g4_adr",  128'(l2_adr), 128'h100);
        chk("c_g4_cnt",  128'(contention_cnt), 128'd8);
        l2_ack = 1;
        tick();                                   // -> RECOVER
        l2_ack = 0;
        i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
        tick(); tick();

        // ---- abort: i drops stb before ack, pending d granted next ----
        rst_n = 0;
        tick();
        rst_n = 1;
        i_cyc = 1; i_stb = 1; i_adr = 12'h3A0;
        tick();                                   // -> GRANT_I
        d_cyc = 1; d_stb = 1; d_adr = 12'h0B0;
        i_stb = 0;
        #1;
        chk("ab_stb",    128'(l2_stb), 128'd0);
        chk("ab_cyc",    128'(l2_cyc), 128'd1);
        chk("ab_adr",    128'(l2_adr), 128'h3A0);
        tick();                                   // abort -> RECOVER
        #1;
        chk("ab_rec_cyc", 128'(l2_cyc), 128'd0);
        i_cyc = 0;
        tick();                                   // -> IDLE
        #1;
        chk("ab_idle_cyc", 128'(l2_cyc), 128'd0);
        tick();                                   // -> GRANT_D
        #1;
        chk("ab_d_cyc",  128'(l2_cyc), 128'd1);
        chk("ab_d_adr",  128'(l2_adr), 128'h0B0);
        chk("ab_cnt",    128'(contention_cnt), 128'd0);

        // ---- reset during GRANT_D, l2_ack arrives the following cycle ----
        i_cyc = 1; i_stb = 1;                     // contended cycles before reset
        tick();
        rst_n = 0;
        tick();                                   // reset edge -> IDLE, cnt 0
        rst_n = 1;
        i_cyc = 0; i_stb = 0;
        l2_ack = 1;
        #1;
        chk("rs_d_ack",  128'(d_ack),  128'd0);
        chk("rs_cyc",    128'(l2_cyc), 128'd0);
        chk("rs_cnt",    128'(contention_cnt), 128'd0);
        tick();                                   // stray ack ignored; d regranted
        l2_ack = 0;
        #1;
        chk("rs_regrant", 128'(l2_cyc), 128'd1);
        d_cyc = 0; d_stb = 0;
        tick(); tick(); tick();

        // ---- counter saturation: both hold requests, L2 never acks ----
        rst_n = 0;
        tick();
        rst_n = 1;
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 128'(contention_cnt), 128'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_ffff", 128'(contention_cnt), 128'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_hold", 128'(contention_cnt), 128'hFFFF);
        chk("sat_gnt_d", 128'(l2_adr), 128'h0B0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
